// File: rtl/xaui_reset_sequencer_pkg.sv
// Shared types and constants for the XAUI GTX reset sequencer.
package xaui_reset_pkg;

  localparam int RETRY_W = 8;

  localparam logic [2:0] ST_RESET     = 3'd0;
  localparam logic [2:0] ST_PMA_HOLD  = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
  localparam logic [2:0] ST_PCS_HOLD  = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_READY     = 3'd5;

  typedef enum logic [2:0] {
    S_RESET     = ST_RESET,
    S_PMA_HOLD  = ST_PMA_HOLD,
    S_WAIT_LOCK = ST_WAIT_LOCK,
    S_PCS_HOLD  = ST_PCS_HOLD,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_READY     = ST_READY
  } seq_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/xaui_reset_sequencer_if.sv
// Status/reset bundle between the GTX quads and the reset sequencer.
interface xaui_reset_sequencer_if import xaui_reset_pkg::*; #(
  parameter int NUM_QUADS = 3
);
  logic [NUM_QUADS*4-1:0] rx_pll_lock;
  logic [NUM_QUADS*4-1:0] rx_resetdone;
  logic [NUM_QUADS*4-1:0] tx_resetdone;
  logic [NUM_QUADS-1:0]   pma_reset;
  logic [NUM_QUADS-1:0]   pcs_reset;
  logic                   ready;
  logic [RETRY_W-1:0]     retry_count;
  logic [2:0]             seq_state;

  modport master (
    output rx_pll_lock, rx_resetdone, tx_resetdone,
    input  pma_reset, pcs_reset, ready, retry_count, seq_state
  );

  modport slave (
    input  rx_pll_lock, rx_resetdone, tx_resetdone,
    output pma_reset, pcs_reset, ready, retry_count, seq_state
  );
endinterface

// File: rtl/xaui_reset_sequencer_sync_bits.sv
// Parametrised-width 2-flop synchroniser, cleared by mgt_reset.
module xaui_sync_bits #(
  parameter int WIDTH = 1
) (
  input  logic             gtx_refclk_bufr,
  input  logic             mgt_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge gtx_refclk_bufr or posedge mgt_reset) begin
    if (mgt_reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/xaui_reset_sequencer.sv
// GTX quad-group reset sequencer: PMA reset, lock wait, PCS reset, done wait, retry.
// Optional feature macro: XAUI_RESET_SEQ_LOL_RECOVERY_EN (loss-of-lock recovery from READY).
//   state     | meaning
//   RESET     | held by mgt_reset, all resets asserted
//   PMA_HOLD  | PMA/PLL reset asserted for PMA_HOLD_CYCLES
//   WAIT_LOCK | PMA released, waiting for PLL lock on enabled quads
//   PCS_HOLD  | PCS reset asserted for PCS_HOLD_CYCLES
//   WAIT_DONE | PCS released, waiting for rx/tx reset-done
//   READY     | all enabled lanes up
module xaui_reset_sequencer import xaui_reset_pkg::*; #(
  parameter int                   NUM_QUADS       = 3,
  parameter logic [NUM_QUADS-1:0] ENABLE_MASK     = {NUM_QUADS{1'b1}},
  parameter int                   PMA_HOLD_CYCLES = 64,
  parameter int                   PCS_HOLD_CYCLES = 16,
  parameter int                   LOCK_TIMEOUT    = 2**16,
  parameter int                   DONE_TIMEOUT    = 2**12
) (
  input  logic                   gtx_refclk_bufr,
  input  logic                   mgt_reset,
  xaui_reset_sequencer_if.slave  bus
);
  localparam int NL    = NUM_QUADS * 4;
  localparam int CNT_W = $clog2(max4(PMA_HOLD_CYCLES, PCS_HOLD_CYCLES, LOCK_TIMEOUT, DONE_TIMEOUT));
  localparam logic [CNT_W-1:0] PMA_LAST  = CNT_W'(PMA_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PCS_LAST  = CNT_W'(PCS_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [NUM_QUADS-1:0] MASKED = ~ENABLE_MASK;

  logic [NL-1:0]        lock_s, rx_s, tx_s;
  logic [NUM_QUADS-1:0] q_lock, q_done;
  logic                 all_lock, all_done;

  xaui_sync_bits #(.WIDTH(NL)) u_sync_lock (
    .gtx_refclk_bufr(gtx_refclk_bufr), .mgt_reset(mgt_reset), .d(bus.rx_pll_lock), .q(lock_s));
  xaui_sync_bits #(.WIDTH(NL)) u_sync_rx (
    .gtx_refclk_bufr(gtx_refclk_bufr), .mgt_reset(mgt_reset), .d(bus.rx_resetdone), .q(rx_s));
  xaui_sync_bits #(.WIDTH(NL)) u_sync_tx (
    .gtx_refclk_bufr(gtx_refclk_bufr), .mgt_reset(mgt_reset), .d(bus.tx_resetdone), .q(tx_s));

  // Masked quads always read as good so they never block the group.
  for (genvar q = 0; q < NUM_QUADS; q++) begin : g_quad
    assign q_lock[q] = ~ENABLE_MASK[q] | (&lock_s[4*q +: 4]);
    assign q_done[q] = ~ENABLE_MASK[q] | ((&rx_s[4*q +: 4]) & (&tx_s[4*q +: 4]));
  end
  assign all_lock = &q_lock;
  assign all_done = &q_done;

  seq_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_QUADS-1:0] pma_q, pcs_q;
  logic                 ready_q;
  logic [RETRY_W-1:0]   retry_q;

  always_ff @(posedge gtx_refclk_bufr or posedge mgt_reset) begin
    if (mgt_reset) begin
      state   <= S_RESET;
      cnt     <= '0;
      pma_q   <= '1;
      pcs_q   <= '1;
      ready_q <= 1'b0;
      retry_q <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        S_RESET: begin
          state <= S_PMA_HOLD;
          cnt   <= '0;
        end
        S_PMA_HOLD: begin
          if (cnt == PMA_LAST) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
            pma_q <= MASKED;
          end
        end
        S_WAIT_LOCK: begin
          if (all_lock) begin
            state <= S_PCS_HOLD;
            cnt   <= '0;
          end else if (cnt == LOCK_LAST) begin
            state   <= S_PMA_HOLD;
            cnt     <= '0;
            pma_q   <= '1;
            retry_q <= sat_inc(retry_q);
          end
        end
        S_PCS_HOLD: begin
          if (cnt == PCS_LAST) begin
            state <= S_WAIT_DONE;
            cnt   <= '0;
            pcs_q <= MASKED;
          end
        end
        S_WAIT_DONE: begin
          // Lock loss outranks both done and timeout.
          if (!all_lock) begin
            state   <= S_PMA_HOLD;
            cnt     <= '0;
            pma_q   <= '1;
            pcs_q   <= '1;
            retry_q <= sat_inc(retry_q);
          end else if (all_done) begin
            state   <= S_READY;
            cnt     <= '0;
            ready_q <= 1'b1;
          end else if (cnt == DONE_LAST) begin
            state   <= S_PCS_HOLD;
            cnt     <= '0;
            pcs_q   <= '1;
            retry_q <= sat_inc(retry_q);
          end
        end
        S_READY: begin
`ifdef XAUI_RESET_SEQ_LOL_RECOVERY_EN
          if (!all_lock) begin
            state   <= S_PMA_HOLD;
            cnt     <= '0;
            pma_q   <= '1;
            pcs_q   <= '1;
            ready_q <= 1'b0;
            retry_q <= sat_inc(retry_q);
          end
`else
          cnt <= '0;
`endif
        end
        default: begin
          state <= S_RESET;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.pma_reset   = pma_q;
  assign bus.pcs_reset   = pcs_q;
  assign bus.ready       = ready_q;
  assign bus.retry_count = retry_q;
  assign bus.seq_state   = state;
endmodule
